// File: rtl/serial_add_seq.sv
// Bit-serial adder: steps two WIDTH-bit operands LSB-first through one add cell.
// Optional subtract mode (port sub) is compiled in with `define SERADD_SUB_EN.
module serial_add_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERADD_SUB_EN
    input  logic             sub,
`endif
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] rega, regb, sreg, sreg_nxt;
    logic [WIDTH-1:0] b_ld;
    logic             c_ld;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             last;
    logic             h1_s, h1_c, h2_c, bit_s, bit_c;

`ifdef SERADD_SUB_EN
    // Subtract as a + ~b + 1; cin has no effect in this mode.
    assign b_ld = sub ? ~b : b;
    assign c_ld = sub | cin;
`else
    assign b_ld = b;
    assign c_ld = cin;
`endif

    assign h1_s  = rega[0] ^ regb[0];
    assign h1_c  = rega[0] & regb[0];
    assign bit_s = h1_s ^ carry;
    assign h2_c  = h1_s & carry;
    assign bit_c = h1_c | h2_c;
    assign last  = (cnt == CW'(WIDTH - 1));

    always_comb begin
        sreg_nxt            = sreg >> 1;
        sreg_nxt[WIDTH-1]   = bit_s;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) state_nxt = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rega  <= '0;
            regb  <= '0;
            sreg  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        rega  <= a;
                        regb  <= b_ld;
                        carry <= c_ld;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    rega  <= rega >> 1;
                    regb  <= regb >> 1;
                    carry <= bit_c;
                    sreg  <= sreg_nxt;
                    // Counter stops on the final bit so it never wraps.
                    if (last) begin
                        sum  <= sreg_nxt;
                        cout <= bit_c;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_add_seq.sv
// Self-checking bench for serial_add_seq: directed cases plus randomized
// operands against an arithmetic reference model.
module tb_serial_add_seq;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a, b;
    logic         cin;
`ifdef SERADD_SUB_EN
    logic         sub;
`endif
    logic         ready, busy, done, cout;
    logic [W-1:0] sum;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    serial_add_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef SERADD_SUB_EN
        .sub   (sub),
`endif
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic ci, input logic sb);
        logic [W-1:0] ny;
        ny = ~y;
        if (sb) return {1'b0, x} + {1'b0, ny} + (W+1)'(1);
        return {1'b0, x} + {1'b0, y} + (W+1)'(ci);
    endfunction

    // Runs one operation; reports done latency (-1 on timeout), result,
    // busy after the accept edge and the idle state one cycle after done.
    task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci,
                         input logic sb, output int lat, output logic [W:0] res,
                         output logic busy_e0, output logic idle_after);
        @(negedge clk);
        a = x; b = y; cin = ci;
`ifdef SERADD_SUB_EN
        sub = sb;
`endif
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start   = 1'b0;
        busy_e0 = busy;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        lat = -1;
        for (int i = 1; i <= W + 4; i++) begin
            @(negedge clk);
            if (done) begin
                lat = i;
                break;
            end
        end
        res = {cout, sum};
        @(negedge clk);
        idle_after = ready && !busy && !done;
    endtask

    task automatic test_reset();
        logic [W+3:0] exp_v;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
`ifdef SERADD_SUB_EN
        sub = 1'b0;
`endif
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        exp_v = {1'b1, 1'b0, 1'b0, 1'b0, {W{1'b0}}};
        tests_run++;
        if ({ready, busy, done, cout, sum} !== exp_v) begin
            tests_failed++;
            $display("FAIL reset_state got=%0h exp=%0h", {ready, busy, done, cout, sum}, exp_v);
        end
    endtask

    task automatic test_basic();
        int lat; logic [W:0] res, exp_r; logic be0, ia;
        exp_r = model(8'h5A, 8'h3C, 1'b0, 1'b0);
        do_op(8'h5A, 8'h3C, 1'b0, 1'b0, lat, res, be0, ia);
        tests_run++;
        if (be0 !== 1'b1) begin tests_failed++; $display("FAIL basic_busy got=%b exp=1", be0); end
        tests_run++;
        if (lat != W) begin tests_failed++; $display("FAIL basic_latency got=%0d exp=%0d", lat, W); end
        tests_run++;
        if (res !== exp_r) begin tests_failed++; $display("FAIL basic_result got=%0h exp=%0h", res, exp_r); end
        tests_run++;
        if (ia !== 1'b1) begin tests_failed++; $display("FAIL basic_ready_after got=%b exp=1", ia); end
        repeat (5) @(negedge clk);
        tests_run++;
        if ({cout, sum} !== exp_r) begin
            tests_failed++; $display("FAIL basic_hold got=%0h exp=%0h", {cout, sum}, exp_r);
        end
    endtask

    task automatic test_carry();
        int lat; logic [W:0] res, exp_r; logic be0, ia;
        exp_r = model(8'hFF, 8'h01, 1'b0, 1'b0);
        do_op(8'hFF, 8'h01, 1'b0, 1'b0, lat, res, be0, ia);
        tests_run++;
        if (lat != W || res !== exp_r) begin
            tests_failed++; $display("FAIL carry_ff01 got=%0h lat=%0d exp=%0h", res, lat, exp_r);
        end
        exp_r = model(8'hFF, 8'h00, 1'b1, 1'b0);
        do_op(8'hFF, 8'h00, 1'b1, 1'b0, lat, res, be0, ia);
        tests_run++;
        if (lat != W || res !== exp_r) begin
            tests_failed++; $display("FAIL carry_ff00_cin got=%0h lat=%0d exp=%0h", res, lat, exp_r);
        end
    endtask

    task automatic test_busy_protect();
        logic [W:0] prev, exp_r, res;
        int ndone;
        prev  = {cout, sum};
        exp_r = model(8'h12, 8'h34, 1'b0, 1'b0);
        res   = '0;
        ndone = 0;
        @(negedge clk);
        a = 8'h12; b = 8'h34; cin = 1'b0;
`ifdef SERADD_SUB_EN
        sub = 1'b0;
`endif
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++;
        if ({cout, sum} !== prev) begin
            tests_failed++; $display("FAIL busy_hold_prev got=%0h exp=%0h", {cout, sum}, prev);
        end
        a = 8'hFF; b = 8'hFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                if (ndone == 1) res = {cout, sum};
            end
        end
        tests_run++;
        if (ndone != 1) begin tests_failed++; $display("FAIL busy_done_count got=%0d exp=1", ndone); end
        tests_run++;
        if (res !== exp_r) begin tests_failed++; $display("FAIL busy_result got=%0h exp=%0h", res, exp_r); end
        tests_run++;
        if (ready !== 1'b1) begin tests_failed++; $display("FAIL busy_idle_after got=%b exp=1", ready); end
    endtask

    task automatic test_reset_mid();
        int ndone, lat; logic [W:0] res, exp_r; logic be0, ia;
        logic [W+3:0] exp_v;
        ndone = 0;
        @(negedge clk);
        a = 8'h80; b = 8'h80; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        exp_v = {1'b1, 1'b0, 1'b0, 1'b0, {W{1'b0}}};
        tests_run++;
        if ({ready, busy, done, cout, sum} !== exp_v) begin
            tests_failed++;
            $display("FAIL rstmid_state got=%0h exp=%0h", {ready, busy, done, cout, sum}, exp_v);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < W + 4; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        tests_run++;
        if (ndone != 0) begin tests_failed++; $display("FAIL rstmid_no_done got=%0d exp=0", ndone); end
        exp_r = model(8'h01, 8'h01, 1'b0, 1'b0);
        do_op(8'h01, 8'h01, 1'b0, 1'b0, lat, res, be0, ia);
        tests_run++;
        if (lat != W || res !== exp_r) begin
            tests_failed++; $display("FAIL rstmid_next_op got=%0h lat=%0d exp=%0h", res, lat, exp_r);
        end
    endtask

    task automatic test_random();
        int lat; logic [W:0] res, exp_r; logic be0, ia;
        logic [W-1:0] x, y; logic ci, sb;
        for (int n = 0; n < 30; n++) begin
            x = W'($urandom); y = W'($urandom); ci = 1'($urandom);
`ifdef SERADD_SUB_EN
            sb = 1'($urandom);
`else
            sb = 1'b0;
`endif
            exp_r = model(x, y, ci, sb);
            do_op(x, y, ci, sb, lat, res, be0, ia);
            tests_run++;
            if (lat != W || res !== exp_r || ia !== 1'b1) begin
                tests_failed++;
                $display("FAIL random_%0d a=%0h b=%0h cin=%b sub=%b got=%0h lat=%0d exp=%0h lat=%0d",
                         n, x, y, ci, sb, res, lat, exp_r, W);
            end
        end
    endtask

    task automatic test_back_to_back();
        int times[$];
        logic [W-1:0] x, y; logic [W:0] exp_r;
        x = W'($urandom); y = W'($urandom);
        exp_r = model(x, y, 1'b0, 1'b0);
        @(negedge clk);
        a = x; b = y; cin = 1'b0;
`ifdef SERADD_SUB_EN
        sub = 1'b0;
`endif
        start = 1'b1;
        for (int i = 1; i <= 3 * (W + 2) + 2; i++) begin
            @(negedge clk);
            if (done) begin
                times.push_back(i);
                tests_run++;
                if ({cout, sum} !== exp_r) begin
                    tests_failed++;
                    $display("FAIL b2b_result_%0d got=%0h exp=%0h", i, {cout, sum}, exp_r);
                end
            end
        end
        start = 1'b0;
        tests_run++;
        if (times.size() != 3) begin
            tests_failed++; $display("FAIL b2b_done_count got=%0d exp=3", times.size());
        end else begin
            tests_run++;
            if (times[0] != W + 1) begin
                tests_failed++; $display("FAIL b2b_first got=%0d exp=%0d", times[0], W + 1);
            end
            for (int k = 1; k < 3; k++) begin
                tests_run++;
                if (times[k] - times[k-1] != W + 2) begin
                    tests_failed++;
                    $display("FAIL b2b_spacing got=%0d exp=%0d", times[k] - times[k-1], W + 2);
                end
            end
        end
        for (int i = 0; i < W + 4 && !ready; i++) @(negedge clk);
        tests_run++;
        if (ready !== 1'b1) begin tests_failed++; $display("FAIL b2b_return_idle got=%b exp=1", ready); end
    endtask

`ifdef SERADD_SUB_EN
    task automatic test_sub();
        int lat; logic [W:0] res, exp_r; logic be0, ia;
        exp_r = model(8'h10, 8'h01, 1'b0, 1'b1);
        do_op(8'h10, 8'h01, 1'b0, 1'b1, lat, res, be0, ia);
        tests_run++;
        if (lat != W || res !== exp_r) begin
            tests_failed++; $display("FAIL sub_10_01 got=%0h lat=%0d exp=%0h", res, lat, exp_r);
        end
        exp_r = model(8'h01, 8'h02, 1'b1, 1'b1);
        do_op(8'h01, 8'h02, 1'b1, 1'b1, lat, res, be0, ia);
        tests_run++;
        if (lat != W || res !== exp_r) begin
            tests_failed++; $display("FAIL sub_01_02 got=%0h lat=%0d exp=%0h", res, lat, exp_r);
        end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_carry();
        test_busy_protect();
        test_reset_mid();
`ifdef SERADD_SUB_EN
        test_sub();
`endif
        test_random();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
